note_sequencer: RTL and testbench

Song-playback controller for the music box. Walks a two-song note ROM and presents one 11-bit `fullnote` code at a time to the tone-generator datapath (0 = rest) for a programmed number of beat ticks. It handles pause/resume, song switching and end-of-song looping. It sits between the user switches (`pause`, `song_sel`) and the existing octave/note divider chain, replacing free-running address counters.

---
 rtl/music_pkg.sv | 30 +++
 rtl/tick_gen.sv | 34 +++
 rtl/note_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and ROM word layout for the music-box note sequencer.
package music_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int DUR_MSB    = 15;
    localparam int DUR_LSB    = 11;
    localparam int NOTE_MSB   = 10;
    localparam int FULLNOTE_W = 11;
    localparam int DUR_W      = DUR_MSB - DUR_LSB + 1;

    localparam logic [DUR_W-1:0] END_MARKER = 5'd0;

    function automatic logic [DUR_W-1:0] word_dur(input logic [15:0] word);
        return word[DUR_MSB:DUR_LSB];
    endfunction

    function automatic logic [FULLNOTE_W-1:0] word_note(input logic [15:0] word);
        return word[NOTE_MSB:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Beat-tick divider: counts enabled clk cycles and pulses once every TICK_DIV of them.
module tick_gen #(
    parameter int TICK_DIV = 6_250_000
) (
    input  logic clk,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Divider counter: clear wins, otherwise count and wrap only while enabled.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign tick = en && (cnt_r == CNT_MAX);

endmodule

// File: rtl/note_sequencer.sv
// Song-playback controller: walks the two-song note ROM and presents one fullnote
// code at a time to the tone datapath, with pause, song switching and looping.
module note_sequencer
    import music_pkg::*;
#(
    parameter int TICK_DIV  = 6_250_000,
    parameter int GAP_TICKS = 1,
    parameter int LOOP      = 1
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  pause,
    input  logic                  song_sel,
    output logic [7:0]            rom_addr,
    input  logic [15:0]           rom_data,
    output logic [FULLNOTE_W-1:0] fullnote,
    output logic                  playing,
    output logic [6:0]            note_idx,
    output logic                  song_done
);

    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam int REM_W = (GAP_W > DUR_W) ? GAP_W : DUR_W;

    state_t                  state_r, state_nxt_s;
    logic [6:0]              idx_r, idx_nxt_s;
    logic                    song_q_r, song_q_nxt_s;
    logic                    sync1_r, sync2_r, sync3_r;
    logic                    pause_r;
    logic [FULLNOTE_W-1:0]   fullnote_r, fullnote_nxt_s;
    logic [REM_W-1:0]        rem_r, rem_nxt_s;
    logic [6:0]              note_idx_r, note_idx_nxt_s;
    logic                    song_done_r, song_done_nxt_s;
    logic [7:0]              rom_addr_r;
    logic                    change_s, tick_s, tick_en_s, tick_clr_s;
    logic [DUR_W-1:0]        dur_s;
    logic [FULLNOTE_W-1:0]   code_s;

    assign dur_s     = word_dur(rom_data);
    assign code_s    = word_note(rom_data);
    assign change_s  = sync2_r ^ sync3_r;
    assign tick_en_s = ((state_r == PLAY) || (state_r == GAP)) && !pause_r;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .RESET (RESET),
        .en    (tick_en_s),
        .clr   (tick_clr_s),
        .tick  (tick_s)
    );

    // Input conditioning: song switch synchronizer with edge-detect stage, pause level.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            pause_r <= 1'b0;
        end else begin
            sync1_r <= song_sel;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            pause_r <= pause;
        end
    end

    // Next-state logic; a song change overrides whatever the current state would do.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        song_q_nxt_s    = song_q_r;
        fullnote_nxt_s  = fullnote_r;
        rem_nxt_s       = rem_r;
        note_idx_nxt_s  = note_idx_r;
        song_done_nxt_s = 1'b0;
        tick_clr_s      = 1'b0;
        if (change_s) begin
            song_q_nxt_s   = sync2_r;
            idx_nxt_s      = 7'd0;
            tick_clr_s     = 1'b1;
            fullnote_nxt_s = {FULLNOTE_W{1'b0}};
            state_nxt_s    = pause_r ? IDLE : FETCH;
        end else begin
            case (state_r)
                IDLE: begin
                    fullnote_nxt_s = {FULLNOTE_W{1'b0}};
                    if (!pause_r) begin
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                FETCH: begin
                    state_nxt_s = LOAD;
                end
                LOAD: begin
                    if (dur_s == END_MARKER) begin
                        song_done_nxt_s = 1'b1;
                        idx_nxt_s       = 7'd0;
                        fullnote_nxt_s  = {FULLNOTE_W{1'b0}};
                        if (LOOP != 0) begin
                            state_nxt_s = FETCH;
                        end else begin
                            state_nxt_s = DONE;
                        end
                    end else begin
                        fullnote_nxt_s = code_s;
                        rem_nxt_s      = REM_W'(dur_s);
                        note_idx_nxt_s = idx_r;
                        tick_clr_s     = 1'b1;
                        state_nxt_s    = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_s) begin
                        if (rem_r == REM_W'(1)) begin
                            fullnote_nxt_s = {FULLNOTE_W{1'b0}};
                            if (GAP_TICKS > 0) begin
                                rem_nxt_s   = REM_W'(GAP_TICKS);
                                state_nxt_s = GAP;
                            end else begin
                                state_nxt_s = NEXT;
                            end
                        end else begin
                            rem_nxt_s = rem_r - REM_W'(1);
                        end
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end
                GAP: begin
                    fullnote_nxt_s = {FULLNOTE_W{1'b0}};
                    if (tick_s) begin
                        if (rem_r == REM_W'(1)) begin
                            state_nxt_s = NEXT;
                        end else begin
                            rem_nxt_s = rem_r - REM_W'(1);
                        end
                    end else begin
                        state_nxt_s = GAP;
                    end
                end
                NEXT: begin
                    idx_nxt_s   = idx_r + 7'd1;
                    state_nxt_s = FETCH;
                end
                DONE: begin
                    fullnote_nxt_s = {FULLNOTE_W{1'b0}};
                    state_nxt_s    = DONE;
                end
                default: begin
                    fullnote_nxt_s = {FULLNOTE_W{1'b0}};
                    idx_nxt_s      = 7'd0;
                    state_nxt_s    = IDLE;
                end
            endcase
        end
    end

    // Sequencer state; the ROM address is latched on every entry into FETCH.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_r     <= IDLE;
            idx_r       <= 7'd0;
            song_q_r    <= 1'b0;
            fullnote_r  <= {FULLNOTE_W{1'b0}};
            rem_r       <= {REM_W{1'b0}};
            note_idx_r  <= 7'd0;
            song_done_r <= 1'b0;
            rom_addr_r  <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            song_q_r    <= song_q_nxt_s;
            fullnote_r  <= fullnote_nxt_s;
            rem_r       <= rem_nxt_s;
            note_idx_r  <= note_idx_nxt_s;
            song_done_r <= song_done_nxt_s;
            if (state_nxt_s == FETCH) begin
                rom_addr_r <= {song_q_nxt_s, idx_nxt_s};
            end
        end
    end

    // Pause silences the datapath straight from the registered pause level.
    assign fullnote  = pause_r ? {FULLNOTE_W{1'b0}} : fullnote_r;
    assign playing   = tick_en_s;
    assign note_idx  = note_idx_r;
    assign song_done = song_done_r;
    assign rom_addr  = rom_addr_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench: looping and non-looping sequencers against a 1-cycle ROM model.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        RESET;
    logic        pause, song_sel, pause2, song_sel2;
    logic [7:0]  rom_addr, rom_addr2;
    logic [15:0] rom_data, rom_data2;
    logic [10:0] fullnote, fullnote2;
    logic        playing, playing2, song_done, song_done2;
    logic [6:0]  note_idx, note_idx2;
    logic [15:0] rom_mem [0:255];

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .LOOP(1)) dut (
        .clk(clk), .RESET(RESET), .pause(pause), .song_sel(song_sel),
        .rom_addr(rom_addr), .rom_data(rom_data), .fullnote(fullnote),
        .playing(playing), .note_idx(note_idx), .song_done(song_done)
    );

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .LOOP(0)) dut_nl (
        .clk(clk), .RESET(RESET), .pause(pause2), .song_sel(song_sel2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .fullnote(fullnote2),
        .playing(playing2), .note_idx(note_idx2), .song_done(song_done2)
    );

    // Behavioural ROMs with one cycle of read latency.
    always @(posedge clk) begin
        rom_data  <= rom_mem[rom_addr];
        rom_data2 <= rom_mem[rom_addr2];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Length of the run of the current fullnote value, starting at this negedge.
    task automatic measure(output logic [10:0] val, output int len, output int dones);
        val = fullnote;
        len = 0;
        dones = 0;
        while (fullnote == val && len < 200) begin
            if (song_done) dones++;
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] v;
        int len, dn, lat, bad, dones_tot;
        logic saw127, seen;

        for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0000;
        rom_mem[0] = {5'd3, 11'h015};
        rom_mem[1] = {5'd2, 11'h020};
        rom_mem[2] = {5'd0, 11'h000};
        for (int i = 0; i < 128; i++) rom_mem[128 + i] = {5'd1, 11'(256 + i)};

        RESET = 1'b1; pause = 1'b0; song_sel = 1'b0; pause2 = 1'b0; song_sel2 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_fullnote", {21'd0, fullnote}, 32'd0);
        check_eq("rst_playing", {31'd0, playing}, 32'd0);
        check_eq("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check_eq("rst_song_done", {31'd0, song_done}, 32'd0);

        // Basic playback
        RESET = 1'b0;
        lat = 0;
        while (fullnote == 11'd0 && lat < 50) begin @(negedge clk); lat++; end
        check_eq("basic_latency", lat, 32'd3);
        check_eq("basic_playing", {31'd0, playing}, 32'd1);
        measure(v, len, dn);
        check_eq("basic_n0_code", {21'd0, v}, 32'h15);
        check_eq("basic_n0_len", len, 32'd12);
        measure(v, len, dn);
        check_eq("basic_gap0_len", len, 32'd7);
        check_eq("basic_n1_idx", {25'd0, note_idx}, 32'd1);
        measure(v, len, dn);
        check_eq("basic_n1_code", {21'd0, v}, 32'h20);
        check_eq("basic_n1_len", len, 32'd8);
        measure(v, len, dn);
        check_eq("basic_end_len", len, 32'd9);
        check_eq("basic_done_pulses", dn, 32'd1);
        check_eq("basic_loop_code", {21'd0, fullnote}, 32'h15);

        // Pause after 5 sounding cycles, hold for 20
        repeat (4) @(negedge clk);
        check_eq("pause_pre_code", {21'd0, fullnote}, 32'h15);
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fullnote != 11'd0 || playing) bad++;
        end
        check_eq("pause_silent_cycles", bad, 32'd0);
        pause = 1'b0;
        @(negedge clk);
        measure(v, len, dn);
        check_eq("pause_resume_code", {21'd0, v}, 32'h15);
        check_eq("pause_resume_len", len, 32'd7);

        // Song switch mid-note
        measure(v, len, dn);
        check_eq("sw_gap_len", len, 32'd7);
        repeat (2) @(negedge clk);
        song_sel = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("sw_hold_code", {21'd0, fullnote}, 32'h20);
        @(negedge clk);
        check_eq("sw_silence", {21'd0, fullnote}, 32'd0);
        check_eq("sw_rom_addr", {24'd0, rom_addr}, 32'h80);
        repeat (2) @(negedge clk);
        check_eq("sw_first_note", {21'd0, fullnote}, 32'h100);
        check_eq("sw_first_idx", {25'd0, note_idx}, 32'd0);

        // Index wrap over 128 unmarked d1 notes
        bad = 0; dones_tot = 0; saw127 = 1'b0;
        for (int k = 1; k <= 128; k++) begin
            measure(v, len, dn);
            dones_tot += dn;
            if (len != 4) bad++;
            measure(v, len, dn);
            dones_tot += dn;
            if (len != 7) bad++;
            if (note_idx != 7'(k % 128) || fullnote != 11'(256 + (k % 128))) bad++;
            if (note_idx == 7'd127) saw127 = 1'b1;
        end
        check_eq("wrap_seq_errs", bad, 32'd0);
        check_eq("wrap_saw_127", {31'd0, saw127}, 32'd1);
        check_eq("wrap_idx0", {25'd0, note_idx}, 32'd0);
        check_eq("wrap_no_done", dones_tot, 32'd0);

        // Asynchronous reset in the middle of note idx 1
        measure(v, len, dn);
        measure(v, len, dn);
        @(negedge clk);
        check_eq("ar_pre_idx", {25'd0, note_idx}, 32'd1);
        @(posedge clk);
        #3;
        RESET = 1'b1;
        song_sel = 1'b0;
        #1;
        check_eq("ar_fullnote", {21'd0, fullnote}, 32'd0);
        check_eq("ar_playing", {31'd0, playing}, 32'd0);
        check_eq("ar_rom_addr", {24'd0, rom_addr}, 32'd0);
        check_eq("ar_note_idx", {25'd0, note_idx}, 32'd0);
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        lat = 0;
        while (fullnote == 11'd0 && lat < 50) begin @(negedge clk); lat++; end
        check_eq("ar_restart_latency", lat, 32'd3);
        check_eq("ar_restart_code", {21'd0, fullnote}, 32'h15);

        // Non-looping instance: stops in DONE until a song change
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (song_done2) seen = 1'b1;
        end
        check_eq("nl_done_seen", {31'd0, seen}, 32'd1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fullnote2 != 11'd0 || playing2 || song_done2) bad++;
        end
        check_eq("nl_stays_done", bad, 32'd0);
        song_sel2 = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("nl_restart_addr", {24'd0, rom_addr2}, 32'h80);
        repeat (2) @(negedge clk);
        check_eq("nl_restart_note", {21'd0, fullnote2}, 32'h100);
        check_eq("nl_restart_playing", {31'd0, playing2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
